// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single fixed-latency RAM port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests instead of fixed DATA priority.
module mem_arbiter #(
    parameter int RAM_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload
);

    typedef enum logic { S_IDLE, S_BUSY } state_t;
    typedef enum logic { G_INST, G_DATA } grant_t;

    localparam logic [3:0] LAST_CNT = 4'(RAM_LAT - 1);

    state_t     r_state;
    grant_t     r_grant;
    logic [3:0] r_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    grant_t     r_last;
`endif

    logic   w_dreq;
    logic   w_busy;
    logic   w_act;
    logic   w_done;
    grant_t w_pick;

    assign w_dreq = dREN | dWEN;
    // Reset masks the access combinationally so an aborted cycle never shows a completion.
    assign w_busy = (r_state == S_BUSY) && !RST;
    assign w_act  = (r_grant == G_DATA) ? w_dreq : iREN;
    assign w_done = w_busy && w_act && (r_cnt == LAST_CNT);

    always_comb begin
        w_pick = w_dreq ? G_DATA : G_INST;
        if (w_dreq && iREN) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_pick = (r_last == G_INST) ? G_DATA : G_INST;
`else
            w_pick = G_DATA;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_grant <= G_INST;
`ifdef ARB_ROUND_ROBIN_EN
            r_last  <= G_INST;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dreq || iREN) begin
                        r_state <= S_BUSY;
                        r_grant <= w_pick;
                        r_cnt   <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last  <= w_pick;
`endif
                    end
                end
                default: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (!w_act || w_done) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // A simultaneous read+write on the data side is treated as a write only.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        iload    = 32'd0;
        dwait    = 1'b1;
        dload    = 32'd0;
        if (w_busy) begin
            if (r_grant == G_DATA) begin
                ramaddr = daddr;
                ramWEN  = dWEN;
                ramREN  = dREN & ~dWEN;
                if (dWEN) begin
                    ramstore = dstore;
                end
                if (w_done) begin
                    dwait = 1'b0;
                    if (!dWEN) begin
                        dload = ramload;
                    end
                end
            end else begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (w_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, a tie-arbitration sequence, then randomized traffic vs. a reference model.
module tb_mem_arbiter;

    localparam int RAM_LAT = 2;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;

    mem_arbiter #(.RAM_LAT(RAM_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
    } in_t;

    typedef struct packed {
        logic        iwait;
        logic [31:0] iload;
        logic        dwait;
        logic [31:0] dload;
        logic        ramren;
        logic        ramwen;
        logic [31:0] ramaddr;
        logic [31:0] ramstore;
    } out_t;

    typedef struct {
        string tag;
        in_t   in;
        out_t  exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an access is "owned" by one side and has run for m_age cycles.
    bit m_busy = 0;
    bit m_own  = 0;
    int m_age  = 0;
`ifdef ARB_ROUND_ROBIN_EN
    bit m_last = 0;
`endif

    function automatic vec_t V(string tag, bit rst, bit ir, logic [31:0] ia, bit dr, bit dw,
                               logic [31:0] da, logic [31:0] ds, logic [31:0] rl,
                               bit eiw, logic [31:0] eil, bit edw, logic [31:0] edl,
                               bit err, bit erw, logic [31:0] era, logic [31:0] ers);
        vec_t v;
        v.tag = tag;
        v.in  = {rst, ir, ia, dr, dw, da, ds, rl};
        v.exp = {eiw, eil, edw, edl, err, erw, era, ers};
        return v;
    endfunction

    task automatic drive(input in_t x);
        RST = x.rst; iREN = x.iren; iaddr = x.iaddr; dREN = x.dren; dWEN = x.dwen;
        daddr = x.daddr; dstore = x.dstore; ramload = x.ramload;
    endtask

    task automatic check(input string tag, input out_t e);
        out_t a;
        a = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got iw=%b il=%h dw=%b dl=%h rr=%b rw=%b ra=%h rs=%h | want iw=%b il=%h dw=%b dl=%h rr=%b rw=%b ra=%h rs=%h",
                     tag, $time, a.iwait, a.iload, a.dwait, a.dload, a.ramren, a.ramwen, a.ramaddr, a.ramstore,
                     e.iwait, e.iload, e.dwait, e.dload, e.ramren, e.ramwen, e.ramaddr, e.ramstore);
        end
    endtask

    function automatic out_t model_exp(in_t x);
        out_t e;
        bit   act;
        bit   done;
        e = '0;
        e.iwait = 1'b1;
        e.dwait = 1'b1;
        if (!x.rst && m_busy) begin
            act  = m_own ? (x.dren || x.dwen) : x.iren;
            done = act && (m_age == RAM_LAT - 1);
            e.ramaddr = m_own ? x.daddr : x.iaddr;
            if (act && m_own) begin
                e.ramwen = x.dwen;
                e.ramren = x.dren && !x.dwen;
                e.ramstore = x.dwen ? x.dstore : 32'd0;
            end else if (act) begin
                e.ramren = 1'b1;
            end
            if (done && m_own) begin
                e.dwait = 1'b0;
                e.dload = x.dwen ? 32'd0 : x.ramload;
            end else if (done) begin
                e.iwait = 1'b0;
                e.iload = x.ramload;
            end
        end
        return e;
    endfunction

    function automatic void model_step(in_t x);
        bit dreq;
        bit act;
        dreq = x.dren || x.dwen;
        if (x.rst) begin
            m_busy = 0; m_own = 0; m_age = 0;
`ifdef ARB_ROUND_ROBIN_EN
            m_last = 0;
`endif
        end else if (!m_busy) begin
            if (x.iren || dreq) begin
                if (x.iren && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
                    m_own = !m_last;
`else
                    m_own = 1'b1;
`endif
                end else begin
                    m_own = dreq;
                end
`ifdef ARB_ROUND_ROBIN_EN
                m_last = m_own;
`endif
                m_busy = 1; m_age = 0;
            end
        end else begin
            act = m_own ? dreq : x.iren;
            if (!act || m_age == RAM_LAT - 1) m_busy = 0;
            else m_age++;
        end
    endfunction

    vec_t        tbl[$];
    logic [31:0] tie_exp[3];
    bit          ireq, dreq;
    int          dkind;
    logic [31:0] ia, da, ds;

    initial begin
        drive('0);
        RST = 1'b1;
        @(posedge CLK); #1;

        tbl.push_back(V("reset0", 1,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("reset1", 1,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("iread_c0", 0,1,'h40,0,0,0,0,'h12345678, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("iread_c1", 0,1,'h40,0,0,0,0,'h12345678, 1,0,1,0,1,0,'h40,0));
        tbl.push_back(V("iread_c2", 0,1,'h40,0,0,0,0,'h12345678, 0,'h12345678,1,0,1,0,'h40,0));
        tbl.push_back(V("iread_c3", 0,0,0,0,0,0,0,'h12345678, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("dwrite_c0", 0,0,0,0,1,'h80,'hDEADBEEF,'h12345678, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("dwrite_c1", 0,0,0,0,1,'h80,'hDEADBEEF,'h12345678, 1,0,1,0,0,1,'h80,'hDEADBEEF));
        tbl.push_back(V("dwrite_c2", 0,0,0,0,1,'h80,'hDEADBEEF,'h12345678, 1,0,0,0,0,1,'h80,'hDEADBEEF));
        tbl.push_back(V("dwrite_c3", 0,0,0,0,0,0,0,'h12345678, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("reset2", 1,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("both_c0", 0,1,'h44,1,0,'h88,0,'hCAFEF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("both_c1", 0,1,'h44,1,0,'h88,0,'hCAFEF00D, 1,0,1,0,1,0,'h88,0));
        tbl.push_back(V("both_c2", 0,1,'h44,1,0,'h88,0,'hCAFEF00D, 1,0,0,'hCAFEF00D,1,0,'h88,0));
        tbl.push_back(V("both_c3", 0,1,'h44,0,0,0,0,'hCAFEF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("both_c4", 0,1,'h44,0,0,0,0,'hCAFEF00D, 1,0,1,0,1,0,'h44,0));
        tbl.push_back(V("both_c5", 0,1,'h44,0,0,0,0,'hCAFEF00D, 0,'hCAFEF00D,1,0,1,0,'h44,0));
        tbl.push_back(V("both_c6", 0,0,0,0,0,0,0,'hCAFEF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("drop_c0", 0,1,'h50,0,0,0,0,'hCAFEF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("drop_c1", 0,0,'h50,0,0,0,0,'hCAFEF00D, 1,0,1,0,0,0,'h50,0));
        tbl.push_back(V("drop_c2", 0,0,'h50,0,0,0,0,'hCAFEF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("drop_c3", 0,1,'h50,0,0,0,0,'hCAFEF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("drop_c4", 0,1,'h50,0,0,0,0,'hCAFEF00D, 1,0,1,0,1,0,'h50,0));
        tbl.push_back(V("drop_c5", 0,1,'h50,0,0,0,0,'hCAFEF00D, 0,'hCAFEF00D,1,0,1,0,'h50,0));
        tbl.push_back(V("drop_c6", 0,0,0,0,0,0,0,'hCAFEF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("abort_c0", 0,0,0,1,0,'h90,0,'h0BADF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("abort_c1", 1,0,0,1,0,'h90,0,'h0BADF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("abort_c2", 0,0,0,1,0,'h90,0,'h0BADF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("abort_c3", 0,0,0,1,0,'h90,0,'h0BADF00D, 1,0,1,0,1,0,'h90,0));
        tbl.push_back(V("abort_c4", 0,0,0,1,0,'h90,0,'h0BADF00D, 1,0,0,'h0BADF00D,1,0,'h90,0));
        tbl.push_back(V("abort_c5", 0,0,0,0,0,0,0,'h0BADF00D, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("rw_c0", 0,0,0,1,1,'hA0,'h11112222,'h55555555, 1,0,1,0,0,0,0,0));
        tbl.push_back(V("rw_c1", 0,0,0,1,1,'hA0,'h11112222,'h55555555, 1,0,1,0,0,1,'hA0,'h11112222));
        tbl.push_back(V("rw_c2", 0,0,0,1,1,'hA0,'h11112222,'h55555555, 1,0,0,0,0,1,'hA0,'h11112222));
        tbl.push_back(V("rw_c3", 0,0,0,0,0,0,0,'h55555555, 1,0,1,0,0,0,0,0));

        foreach (tbl[k]) begin
            drive(tbl[k].in);
            @(negedge CLK);
            check(tbl[k].tag, tbl[k].exp);
            @(posedge CLK); #1;
        end

        // Three back-to-back ties: both sides hold requests, grant visible in each access's first BUSY cycle.
        tie_exp[0] = 32'h200;
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp[1] = 32'h100;
`else
        tie_exp[1] = 32'h200;
`endif
        tie_exp[2] = 32'h200;
        drive('0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200;
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            if (k % 3 == 1) begin
                n_cmp++;
                if (ramaddr !== tie_exp[k / 3] || ramREN !== 1'b1) begin
                    n_bad++;
                    $display("FAIL tie%0d got ramaddr=%h ramREN=%b want ramaddr=%h ramREN=1",
                             k / 3, ramaddr, ramREN, tie_exp[k / 3]);
                end
            end
            @(posedge CLK); #1;
        end

        // Randomized traffic against the reference model, starting from reset.
        ireq = 0; dreq = 0; dkind = 0; ia = 0; da = 0; ds = 0;
        for (int c = 0; c < 3000; c++) begin
            in_t  x;
            out_t e;
            if (!ireq && $urandom_range(0, 2) == 0) begin
                ireq = 1; ia = $urandom;
            end else if (ireq && $urandom_range(0, 24) == 0) begin
                ireq = 0;
            end
            if (!dreq && $urandom_range(0, 2) == 0) begin
                dreq = 1; dkind = $urandom_range(0, 2); da = $urandom; ds = $urandom;
            end else if (dreq && $urandom_range(0, 24) == 0) begin
                dreq = 0;
            end
            x.rst     = (c == 0) || ($urandom_range(0, 59) == 0);
            x.iren    = ireq;
            x.iaddr   = ia;
            x.dren    = dreq && (dkind != 1);
            x.dwen    = dreq && (dkind != 0);
            x.daddr   = da;
            x.dstore  = ds;
            x.ramload = $urandom;
            drive(x);
            e = model_exp(x);
            @(negedge CLK);
            check("random", e);
            if (!e.iwait) ireq = 0;
            if (!e.dwait) dreq = 0;
            model_step(x);
            @(posedge CLK); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
